// File: rtl/scfifo_flagged.sv
// ---------------------------------------------------------------------------
// scfifo_flagged
//   Single-clock FIFO with occupancy count, almost-full/almost-empty flags,
//   sticky overflow/underflow flags, synchronous flush and an optional
//   show-ahead (first-word-fall-through) read port.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   reset        : asynchronous active-high reset
//   sclr         : synchronous flush (empties FIFO, clears sticky flags)
//   data         : write data
//   wrreq        : write request
//   rdreq        : read request / pop of head in show-ahead mode
//   q            : read data
//   rdempty      : FIFO empty
//   wrfull       : FIFO full
//   usedw        : occupancy, 0..FIFO_DEPTH
//   almost_full  : usedw >= AF_THRESH
//   almost_empty : usedw <= AE_THRESH
//   overflow     : sticky, a write was dropped
//   underflow    : sticky, a read hit an empty FIFO
// ---------------------------------------------------------------------------
module scfifo_flagged #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 64,
    parameter int SHOWAHEAD  = 0,
    parameter int AF_THRESH  = FIFO_DEPTH - 8,
    parameter int AE_THRESH  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclr,
    input  logic [DATA_WIDTH-1:0]         data,
    input  logic                          wrreq,
    input  logic                          rdreq,
    output logic [DATA_WIDTH-1:0]         q,
    output logic                          rdempty,
    output logic                          wrfull,
    output logic [$clog2(FIFO_DEPTH):0]   usedw,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Thresholds narrowed once to the counter width so all compares are
    // same-width; FIFO_DEPTH itself needs the extra bit of the counter.
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT    = AF_THRESH[AW:0];
    localparam logic [AW:0] AE_CNT    = AE_THRESH[AW:0];

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  rd_ok;
    logic                  wr_ok;

    // All status flags come from the registered count only.
    assign rdempty      = (usedw == '0);
    assign wrfull       = (usedw == DEPTH_CNT);
    assign almost_full  = (usedw >= AF_CNT);
    assign almost_empty = (usedw <= AE_CNT);

    // A full FIFO can still take a write when a read frees a slot this cycle.
    assign rd_ok = rdreq && !rdempty;
    assign wr_ok = wrreq && (!wrfull || rd_ok);

    // Pointers, occupancy and sticky error flags. The pointer MSB is a wrap
    // bit; the low bits index memory and wrap naturally modulo the depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            usedw     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
            if (wrreq && !wr_ok) begin
                overflow <= 1'b1;
            end
            if (rdreq && rdempty) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage array; deliberately not reset or flushed.
    always_ff @(posedge clk) begin
        if (!sclr && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= data;
        end
    end

    generate
        if (SHOWAHEAD == 0) begin : g_normal
            logic [DATA_WIDTH-1:0] q_reg;

            // Registered read port: head captured on an accepted read,
            // held otherwise (including on rejected reads).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_reg <= '0;
                end else if (sclr) begin
                    q_reg <= '0;
                end else if (rd_ok) begin
                    q_reg <= mem[rd_ptr[AW-1:0]];
                end
            end

            assign q = q_reg;
        end else begin : g_showahead
            // Head of queue presented directly; meaningless while empty.
            assign q = mem[rd_ptr[AW-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_scfifo_flagged.sv
// ---------------------------------------------------------------------------
// tb_scfifo_flagged
//   Drives three FIFO configurations with a shared stimulus stream and
//   compares every output against a queue-based reference model:
//     inst 0 : depth 4, registered read, AF=3, AE=1
//     inst 1 : depth 4, show-ahead read, AF=3, AE=1
//     inst 2 : depth 8, registered read, AF=6, AE=1
// ---------------------------------------------------------------------------
module tb_scfifo_flagged;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          sclr;
    logic [DW-1:0] data;
    logic          wrreq;
    logic          rdreq;

    logic [DW-1:0] q_o      [3];
    logic          rdempty_o[3];
    logic          wrfull_o [3];
    logic          af_o     [3];
    logic          ae_o     [3];
    logic          ovf_o    [3];
    logic          unf_o    [3];
    logic [2:0]    uw0;
    logic [2:0]    uw1;
    logic [3:0]    uw2;
    logic [3:0]    uw_o     [3];

    assign uw_o[0] = {1'b0, uw0};
    assign uw_o[1] = {1'b0, uw1};
    assign uw_o[2] = uw2;

    int m_depth[3] = '{4, 4, 8};
    int m_sa   [3] = '{0, 1, 0};
    int m_af   [3] = '{3, 3, 6};
    int m_ae   [3] = '{1, 1, 1};

    logic [DW-1:0] model_q [3][$];
    logic [DW-1:0] m_qexp  [3];
    bit            m_ovf   [3];
    bit            m_unf   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scfifo_flagged #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .SHOWAHEAD(0),
                     .AF_THRESH(3), .AE_THRESH(1)) u_norm4 (
        .clk(clk), .reset(reset), .sclr(sclr), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q_o[0]), .rdempty(rdempty_o[0]),
        .wrfull(wrfull_o[0]), .usedw(uw0), .almost_full(af_o[0]),
        .almost_empty(ae_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

    scfifo_flagged #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .SHOWAHEAD(1),
                     .AF_THRESH(3), .AE_THRESH(1)) u_sa4 (
        .clk(clk), .reset(reset), .sclr(sclr), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q_o[1]), .rdempty(rdempty_o[1]),
        .wrfull(wrfull_o[1]), .usedw(uw1), .almost_full(af_o[1]),
        .almost_empty(ae_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

    scfifo_flagged #(.DATA_WIDTH(DW), .FIFO_DEPTH(8), .SHOWAHEAD(0),
                     .AF_THRESH(6), .AE_THRESH(1)) u_norm8 (
        .clk(clk), .reset(reset), .sclr(sclr), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q_o[2]), .rdempty(rdempty_o[2]),
        .wrfull(wrfull_o[2]), .usedw(uw2), .almost_full(af_o[2]),
        .almost_empty(ae_o[2]), .overflow(ovf_o[2]), .underflow(unf_o[2]));

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Reference model: a plain queue per instance, advanced once per edge.
    task automatic resetModel();
        for (int i = 0; i < 3; i++) begin
            model_q[i].delete();
            m_qexp[i] = '0;
            m_ovf[i]  = 1'b0;
            m_unf[i]  = 1'b0;
        end
    endtask

    task automatic stepModel(input bit w, input bit r, input bit clr,
                             input logic [DW-1:0] d);
        for (int i = 0; i < 3; i++) begin
            int n;
            bit can_rd;
            bit can_wr;
            logic [DW-1:0] head;
            n = model_q[i].size();
            if (clr) begin
                model_q[i].delete();
                m_ovf[i]  = 1'b0;
                m_unf[i]  = 1'b0;
                m_qexp[i] = '0;
            end else begin
                can_rd = r && (n > 0);
                can_wr = w && ((n < m_depth[i]) || can_rd);
                if (r && n == 0) m_unf[i] = 1'b1;
                if (w && !can_wr) m_ovf[i] = 1'b1;
                if (can_rd) begin
                    head = model_q[i].pop_front();
                    if (m_sa[i] == 0) m_qexp[i] = head;
                end
                if (can_wr) model_q[i].push_back(d);
            end
        end
    endtask

    task automatic checkAll(input string phase);
        for (int i = 0; i < 3; i++) begin
            int n;
            n = model_q[i].size();
            checkOutput($sformatf("%s.i%0d.usedw", phase, i), 32'(uw_o[i]), 32'(n));
            checkOutput($sformatf("%s.i%0d.rdempty", phase, i), 32'(rdempty_o[i]), 32'(n == 0));
            checkOutput($sformatf("%s.i%0d.wrfull", phase, i), 32'(wrfull_o[i]), 32'(n == m_depth[i]));
            checkOutput($sformatf("%s.i%0d.afull", phase, i), 32'(af_o[i]), 32'(n >= m_af[i]));
            checkOutput($sformatf("%s.i%0d.aempty", phase, i), 32'(ae_o[i]), 32'(n <= m_ae[i]));
            checkOutput($sformatf("%s.i%0d.overflow", phase, i), 32'(ovf_o[i]), 32'(m_ovf[i]));
            checkOutput($sformatf("%s.i%0d.underflow", phase, i), 32'(unf_o[i]), 32'(m_unf[i]));
            if (m_sa[i] == 0) begin
                checkOutput($sformatf("%s.i%0d.q", phase, i), 32'(q_o[i]), 32'(m_qexp[i]));
            end else if (n > 0) begin
                checkOutput($sformatf("%s.i%0d.q", phase, i), 32'(q_o[i]), 32'(model_q[i][0]));
            end
        end
    endtask

    // One clock of stimulus: drive after the falling edge, let the model
    // see the same inputs at the rising edge, check on the next falling edge.
    task automatic applyStimulus(input bit w, input bit r, input bit clr,
                                 input logic [DW-1:0] d, input string phase);
        wrreq = w;
        rdreq = r;
        sclr  = clr;
        data  = d;
        @(posedge clk);
        stepModel(w, r, clr, d);
        @(negedge clk);
        checkAll(phase);
    endtask

    initial begin
        reset = 1'b1;
        sclr  = 1'b0;
        wrreq = 1'b0;
        rdreq = 1'b0;
        data  = '0;
        resetModel();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkAll("reset");

        // Fill then drain in order.
        applyStimulus(1, 0, 0, 16'h000A, "fill");
        applyStimulus(1, 0, 0, 16'h000B, "fill");
        applyStimulus(1, 0, 0, 16'h000C, "fill");
        applyStimulus(1, 0, 0, 16'h000D, "fill");
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, '0, "drain");
        applyStimulus(0, 0, 0, '0, "idle");

        // Full with simultaneous read/write, then a dropped write and
        // reads past empty, then flush.
        applyStimulus(1, 0, 0, 16'h000A, "refill");
        applyStimulus(1, 0, 0, 16'h000B, "refill");
        applyStimulus(1, 0, 0, 16'h000C, "refill");
        applyStimulus(1, 0, 0, 16'h000D, "refill");
        applyStimulus(1, 1, 0, 16'h000E, "rdwr_full");
        applyStimulus(1, 0, 0, 16'h00F0, "ovf");
        for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, '0, "drain_unf");
        applyStimulus(1, 1, 0, 16'h0011, "rdwr_empty");
        applyStimulus(0, 0, 1, '0, "sclr");
        applyStimulus(1, 1, 1, 16'h0022, "sclr_prio");

        // Threshold walk on the depth-8 instance.
        for (int k = 0; k < 9; k++) applyStimulus(1, 0, 0, 16'(16'h0100 + k), "thresh");
        applyStimulus(0, 0, 1, '0, "sclr2");

        // Show-ahead visibility.
        applyStimulus(1, 0, 0, 16'h0055, "sa_w1");
        applyStimulus(1, 0, 0, 16'h0066, "sa_w2");
        applyStimulus(0, 1, 0, '0, "sa_pop");
        applyStimulus(0, 1, 0, '0, "sa_pop");

        // Wrap-around write/read pairs.
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 0, 0, 16'(16'h0200 + k), "wrap_w");
            applyStimulus(0, 1, 0, '0, "wrap_r");
        end

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                          $urandom_range(0, 59) == 0, 16'($urandom()), "rand");
        end

        // Asynchronous reset mid-stream with three entries queued.
        applyStimulus(0, 0, 1, '0, "pre_rst");
        applyStimulus(1, 0, 0, 16'h0301, "pre_rst");
        applyStimulus(1, 0, 0, 16'h0302, "pre_rst");
        applyStimulus(1, 1, 0, 16'h0303, "pre_rst");
        applyStimulus(1, 0, 0, 16'h0304, "pre_rst");
        wrreq = 1'b0;
        rdreq = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        resetModel();
        checkAll("async_rst");
        @(negedge clk);
        reset = 1'b0;
        checkAll("post_rst");
        applyStimulus(1, 0, 0, 16'h0077, "post_w");
        applyStimulus(0, 1, 0, '0, "post_r");
        applyStimulus(0, 0, 0, '0, "post_idle");
        applyStimulus(0, 1, 0, '0, "post_unf");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
